// File: rtl/mmio_result_responder_if.sv
// mmio_result_responder_if
//   Bus bundle between the data-side responder and its two initiators.
//   The core drives cpu_*, and the external initiator (CPU_driver) drives ext_*.
//   The responder returns load data and the assembled result byte.
//   Signals:
//     cpu_mem_write / cpu_addr / cpu_wdata : core store strobe, byte address, store data
//     cpu_rdata                            : registered load data for cpu_addr
//     ext_mem_write / ext_addr / ext_wdata : external initiator store strobe, address, data
//     result / result_valid / overflow     : completed result byte, update pulse, sticky overflow
//   Modports: slave = responder side, master = initiator/testbench side.
interface mmio_result_responder_if #(
  parameter int RES_W = 8
);
  logic             cpu_mem_write;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [31:0]      cpu_rdata;
  logic             ext_mem_write;
  logic [31:0]      ext_addr;
  logic [31:0]      ext_wdata;
  logic [RES_W-1:0] result;
  logic             result_valid;
  logic             overflow;

  modport slave (
    input  cpu_mem_write, cpu_addr, cpu_wdata,
    input  ext_mem_write, ext_addr, ext_wdata,
    output cpu_rdata, result, result_valid, overflow
  );

  modport master (
    output cpu_mem_write, cpu_addr, cpu_wdata,
    output ext_mem_write, ext_addr, ext_wdata,
    input  cpu_rdata, result, result_valid, overflow
  );
endinterface

// File: rtl/mmio_result_responder.sv
// mmio_result_responder
//   Data-side responder between the RISC-V core's load/store port and data RAM.
//   It serves core loads and stores as well as external-initiator stores.
//   It decodes a 256-byte MMIO window at MMIO_BASE.
//   It assembles single-bit stores to OUT_BIT into a RES_W-bit result.
//   Ports:
//     clk   : system clock, all state changes on the rising edge
//     reset : synchronous, active-high; clears every register except RAM
//     bus   : mmio_result_responder_if.slave (see interface file for the signal list)
//   MMIO map (offset from MMIO_BASE):
//     0x00 OUT_BIT  W: capture wdata[0]    R: shift register
//     0x04 EP_REG   32-bit scratch register
//     0x08 STATUS   R: {drop, overflow, full, bit_cnt mod 4}  W: wdata[0]=1 clears
module mmio_result_responder #(
  parameter int          RAM_AW    = 8,
  parameter logic [31:0] MMIO_BASE = 32'h0200_0000,
  parameter int          RES_W     = 8
) (
  input logic                    clk,
  input logic                    reset,
  mmio_result_responder_if.slave bus
);

  localparam int CNT_W = $clog2(RES_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [RES_W-1:0] shift_q, shift_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             overflow_q, overflow_d;
  logic             drop_q, drop_d;
  logic [31:0]      ep_q, ep_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      ram_q [2**RAM_AW];

  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             wr_mmio;
  logic             wr_outbit;
  logic             wr_ep;
  logic             wr_clear;
  logic             ram_we;
  logic [RAM_AW-1:0] ram_widx;

  // Single winning write per cycle: the external initiator beats the core.
  always_comb begin
    wr_en   = bus.ext_mem_write | bus.cpu_mem_write;
    wr_addr = bus.ext_mem_write ? bus.ext_addr  : bus.cpu_addr;
    wr_data = bus.ext_mem_write ? bus.ext_wdata : bus.cpu_wdata;
  end

  // Decode of the winning write address.
  // Upper address bits beyond the RAM alias onto the same words.
  always_comb begin
    wr_mmio   = wr_en && (wr_addr[31:8] == MMIO_BASE[31:8]);
    wr_outbit = wr_mmio && (wr_addr[7:0] == 8'h00);
    wr_ep     = wr_mmio && (wr_addr[7:0] == 8'h04);
    wr_clear  = wr_mmio && (wr_addr[7:0] == 8'h08) && wr_data[0];
    ram_we    = wr_en && !wr_mmio && !reset;
    ram_widx  = wr_addr[RAM_AW+1:2];
  end

  // Load path: decode cpu_addr against the current register and RAM contents.
  // The result is registered, so a same-cycle store is seen only on the next load.
  always_comb begin
    rdata_d = '0;
    if (bus.cpu_addr[31:8] == MMIO_BASE[31:8]) begin
      case (bus.cpu_addr[7:0])
        8'h00:   rdata_d[RES_W-1:0] = shift_q;
        8'h04:   rdata_d = ep_q;
        8'h08:   rdata_d = {27'b0, drop_q, overflow_q, (state_q == FULL), 2'(bit_cnt_q)};
        default: rdata_d = '0;
      endcase
    end else begin
      rdata_d = ram_q[bus.cpu_addr[RAM_AW+1:2]];
    end
  end

  // Capture FSM and MMIO register updates.
  // A clear and an OUT_BIT store cannot coincide because only one write wins per cycle.
  // A dropped core write is recorded after any clear, so the drop of this cycle stays visible.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    overflow_d     = overflow_q;
    drop_d         = drop_q;
    ep_d           = ep_q;

    if (wr_clear) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      shift_d    = '0;
      overflow_d = 1'b0;
      drop_d     = 1'b0;
    end else if (wr_outbit) begin
      case (state_q)
        IDLE: begin
          shift_d   = RES_W'(wr_data[0]);
          bit_cnt_d = CNT_W'(1);
          state_d   = CAPTURE;
        end
        CAPTURE: begin
          shift_d[bit_cnt_q] = wr_data[0];
          if (bit_cnt_q == CNT_W'(RES_W - 1)) begin
            result_d       = shift_d;
            result_valid_d = 1'b1;
            bit_cnt_d      = '0;
            state_d        = FULL;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        FULL: begin
          overflow_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (wr_ep) begin
      ep_d = wr_data;
    end

    if (bus.ext_mem_write && bus.cpu_mem_write) begin
      drop_d = 1'b1;
    end
  end

  // State registers. Reset discards any partial capture and the last result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      drop_q         <= 1'b0;
      ep_q           <= '0;
      rdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
      drop_q         <= drop_d;
      ep_q           <= ep_d;
      rdata_q        <= rdata_d;
    end
  end

  // Data RAM is never cleared. Writes are blocked while reset is high.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_widx] <= wr_data;
    end
  end

  assign bus.cpu_rdata    = rdata_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.overflow     = overflow_q;

endmodule
